// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

    // Sequencer phases: wait for sync, hold, staggered release, running.
    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_STRETCH,
        ST_RELEASE,
        ST_RUN
    } state_t;

    // Bits needed to hold 0..max_count; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        if (max_count == 0) begin
            return 1;
        end
        return int'($clog2(max_count + 1));
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset synchroniser: asserts asynchronously, deasserts after STAGES falling edges.
module rst_sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic sync_out
);

    logic [STAGES-1:0] chain;

    // Shift ones in from the bottom once rst is gone; rst clears the whole chain.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: synchronise, stretch, then release domains
// one at a time with a fixed stagger. Software requests re-run the stretch.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_OUT        = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned STAGGER_CYCLES = 4
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               sw_rst_req,
    output logic [NUM_OUT-1:0] rst_n,
    output logic               seq_done
);

    localparam int unsigned STR_W = cnt_width(STRETCH_CYCLES);
    localparam int unsigned STG_W = cnt_width(STAGGER_CYCLES);
    localparam int unsigned IDX_W = cnt_width(NUM_OUT - 1);

    localparam logic [STR_W-1:0] STR_MAX  = STR_W'(STRETCH_CYCLES);
    localparam logic [STG_W-1:0] STG_MAX  = STG_W'(STAGGER_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUT - 1);

    state_t             state, state_d;
    logic [NUM_OUT-1:0] rst_n_d;
    logic               seq_done_d;
    logic [STR_W-1:0]   str_cnt, str_cnt_d;
    logic [STG_W-1:0]   stg_cnt, stg_cnt_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic               sync_out;

    rst_sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (RST),
        .sync_out(sync_out)
    );

    // Next-state logic. The ASSERT edge that first sees the synchroniser high
    // already counts as the first stretch edge, so it shares the STRETCH step;
    // that keeps power-on and software-reset release timing on one formula.
    always_comb begin
        state_d    = state;
        rst_n_d    = rst_n;
        seq_done_d = seq_done;
        str_cnt_d  = str_cnt;
        stg_cnt_d  = stg_cnt;
        idx_d      = idx;

        if (state != ST_ASSERT && sw_rst_req) begin
            state_d    = ST_STRETCH;
            rst_n_d    = '0;
            seq_done_d = 1'b0;
            str_cnt_d  = '0;
            stg_cnt_d  = '0;
            idx_d      = '0;
        end else if (state == ST_STRETCH || (state == ST_ASSERT && sync_out)) begin
            if (str_cnt == STR_MAX) begin
                if (STAGGER_CYCLES == 0 || NUM_OUT == 1) begin
                    rst_n_d    = '1;
                    seq_done_d = 1'b1;
                    state_d    = ST_RUN;
                end else begin
                    rst_n_d   = NUM_OUT'(1);
                    idx_d     = IDX_W'(1);
                    stg_cnt_d = STG_W'(1);
                    state_d   = ST_RELEASE;
                end
            end else begin
                str_cnt_d = str_cnt + 1'b1;
                state_d   = ST_STRETCH;
            end
        end else begin
            case (state)
                ST_ASSERT: begin
                    rst_n_d    = '0;
                    seq_done_d = 1'b0;
                    str_cnt_d  = '0;
                    stg_cnt_d  = '0;
                    idx_d      = '0;
                end
                ST_RELEASE: begin
                    if (stg_cnt == STG_MAX) begin
                        rst_n_d   = rst_n | (NUM_OUT'(1) << idx);
                        stg_cnt_d = STG_W'(1);
                        if (idx == IDX_LAST) begin
                            seq_done_d = 1'b1;
                            state_d    = ST_RUN;
                        end else begin
                            idx_d = idx + 1'b1;
                        end
                    end else begin
                        stg_cnt_d = stg_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM state and output flops; RST clears them without a clock.
    always_ff @(negedge clk or posedge RST) begin
        if (RST) begin
            state    <= ST_ASSERT;
            rst_n    <= '0;
            seq_done <= 1'b0;
        end else begin
            state    <= state_d;
            rst_n    <= rst_n_d;
            seq_done <= seq_done_d;
        end
    end

    // Counters carry no reset; the FSM clears them on every ASSERT edge.
    always_ff @(negedge clk) begin
        str_cnt <= str_cnt_d;
        stg_cnt <= stg_cnt_d;
        idx     <= idx_d;
    end

endmodule
